// File: rtl/vread_pkg.sv
// Shared types and constants for the vector-read sequencer slice.
package vread_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/vread_sequencer_if.sv
// Request, register-file and output-stream signals of the vector-read sequencer.
interface vread_sequencer_if #(
   parameter int WIDTH       = 32,
   parameter int LOG2NUMREGS = 4
);

   logic                   req_valid;
   logic                   req_ready;
   logic [LOG2NUMREGS-1:0] req_base;
   logic [LOG2NUMREGS:0]   req_len;
   logic                   cancel;
   logic [LOG2NUMREGS-1:0] rf_reg;
   logic                   rf_en;
   logic [WIDTH-1:0]       rf_readdata;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic [LOG2NUMREGS-1:0] out_idx;
   logic                   out_last;

   modport slave (
      input  req_valid, req_base, req_len, cancel, rf_readdata, out_ready,
      output req_ready, rf_reg, rf_en, out_valid, out_data, out_idx, out_last
   );

   modport master (
      output req_valid, req_base, req_len, cancel, rf_readdata, out_ready,
      input  req_ready, rf_reg, rf_en, out_valid, out_data, out_idx, out_last
   );

endinterface

// File: rtl/vread_skid.sv
// Two-entry FIFO holding register-file read results; entry 0 is always the head.
module vread_skid
   import vread_pkg::*;
#(
   parameter int PAYLOAD_W = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  pop,
   input  logic [PAYLOAD_W-1:0]  din,
   output logic [PAYLOAD_W-1:0]  dout,
   output logic                  valid,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [PAYLOAD_W-1:0] mem0;
   logic [PAYLOAD_W-1:0] mem1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
         mem0  <= '0;
         mem1  <= '0;
      end else if (clr) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == '0) mem0 <= din;
               else             mem1 <= din;
               count <= count + FIFO_CNT_W'(1);
            end
            2'b01: begin
               mem0  <= mem1;
               count <= count - FIFO_CNT_W'(1);
            end
            // Simultaneous push/pop keeps the count; the new entry lands behind the survivor.
            2'b11: begin
               if (count == FIFO_CNT_W'(1)) begin
                  mem0 <= din;
               end else begin
                  mem0 <= mem1;
                  mem1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = mem0;
   assign valid = (count != '0);

endmodule

// File: rtl/vread_sequencer.sv
// Issues register-file reads for a base/length vector and streams the results in index order.
module vread_sequencer
   import vread_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NUMREGS     = 16,
   parameter int LOG2NUMREGS = 4
) (
   input  logic              clk,
   input  logic              resetn,
   vread_sequencer_if.slave  bus
);

   localparam int CW = LOG2NUMREGS + 1;
   localparam int PW = WIDTH + LOG2NUMREGS + 1;

   state_t                 state;
   state_t                 state_nxt;
   logic [LOG2NUMREGS-1:0] base;
   logic [CW-1:0]          len;
   logic [CW-1:0]          issue_cnt;
   logic                   inflight;
   logic [LOG2NUMREGS-1:0] inflight_idx;
   logic                   inflight_last;

   logic [FIFO_CNT_W-1:0]  fifo_count;
   logic                   fifo_valid;
   logic [PW-1:0]          fifo_dout;

   logic                   pop;
   logic                   push;
   logic                   accept;
   logic                   issue;
   logic                   issue_ok;
   logic                   issue_last;
   logic [2:0]             occupancy;
   logic [CW-1:0]          addr_sum;

   assign pop        = fifo_valid & bus.out_ready;
   assign push       = inflight & ~bus.cancel;
   // Count the read in flight as already occupying a slot so the FIFO can never overflow.
   assign occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
   assign issue_ok   = (occupancy < 3'(FIFO_DEPTH));
   assign issue_last = (issue_cnt == len - CW'(1));
   assign addr_sum   = CW'(base) + issue_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.cancel) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.req_valid && bus.req_len != '0) state_nxt = RUN;
            RUN:     if (issue && issue_last)               state_nxt = DRAIN;
            DRAIN:   if (!inflight && !fifo_valid)          state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.req_ready = (state == IDLE);
      accept        = (state == IDLE) && bus.req_valid && !bus.cancel && (bus.req_len != '0);
      issue         = (state == RUN) && issue_ok && !bus.cancel;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         base          <= '0;
         len           <= '0;
         issue_cnt     <= '0;
         inflight      <= 1'b0;
         inflight_idx  <= '0;
         inflight_last <= 1'b0;
      end else begin
         inflight <= issue;
         if (accept) begin
            base      <= bus.req_base;
            len       <= bus.req_len;
            issue_cnt <= '0;
         end else if (issue) begin
            issue_cnt     <= issue_cnt + CW'(1);
            inflight_idx  <= issue_cnt[LOG2NUMREGS-1:0];
            inflight_last <= issue_last;
         end
      end
   end

   assign bus.rf_en  = issue;
   assign bus.rf_reg = (addr_sum >= CW'(NUMREGS))
                     ? addr_sum[LOG2NUMREGS-1:0] - LOG2NUMREGS'(NUMREGS)
                     : addr_sum[LOG2NUMREGS-1:0];

   vread_skid #(
      .PAYLOAD_W (PW)
   ) u_skid (
      .clk    (clk),
      .resetn (resetn),
      .clr    (bus.cancel),
      .push   (push),
      .pop    (pop),
      .din    ({bus.rf_readdata, inflight_idx, inflight_last}),
      .dout   (fifo_dout),
      .valid  (fifo_valid),
      .count  (fifo_count)
   );

   assign bus.out_valid = fifo_valid;
   assign {bus.out_data, bus.out_idx, bus.out_last} = fifo_dout;

endmodule

// File: tb/tb_vread_sequencer.sv
// Directed and randomized bench for vread_sequencer against a queue-based reference model.
module tb_vread_sequencer;

   localparam int WIDTH       = 32;
   localparam int NUMREGS     = 16;
   localparam int LOG2NUMREGS = 4;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               idx;
      logic             last;
   } elem_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   vread_sequencer_if #(.WIDTH(WIDTH), .LOG2NUMREGS(LOG2NUMREGS)) bus ();

   vread_sequencer #(
      .WIDTH       (WIDTH),
      .NUMREGS     (NUMREGS),
      .LOG2NUMREGS (LOG2NUMREGS)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   logic [WIDTH-1:0] mem [NUMREGS];
   elem_t            exp_q [$];
   int               addr_q [$];
   int               n_cmp  = 0;
   int               n_err  = 0;
   int               rd_cnt = 0;
   int               ov_cnt = 0;
   logic             en_s   = 1'b0;
   int               reg_s  = 0;
   logic             hold_v = 1'b0;
   logic [WIDTH-1:0] hold_d = '0;
   int               hold_i = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < NUMREGS; i++) mem[i] = $urandom;
   endtask

   // Model: a request of len elements reads registers (base+i) mod NUMREGS, emitted in order.
   task automatic request(input int base, input int len);
      int t = 0;
      while (!bus.req_ready && t < 100) begin
         cyc(1);
         t++;
      end
      chk("req_ready_wait", 64'(t < 100), 64'(1));
      for (int i = 0; i < len; i++) begin
         exp_q.push_back('{mem[(base + i) % NUMREGS], i, (i == len - 1)});
         addr_q.push_back((base + i) % NUMREGS);
      end
      bus.req_valid = 1'b1;
      bus.req_base  = LOG2NUMREGS'(base);
      bus.req_len   = (LOG2NUMREGS + 1)'(len);
      cyc(1);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain(input int budget, input bit rand_ready);
      int t = 0;
      while ((exp_q.size() != 0 || !bus.req_ready) && t < budget) begin
         if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
         cyc(1);
         t++;
      end
      chk("drain_timeout", 64'(t < budget), 64'(1));
      chk("drain_all_seen", 64'(exp_q.size()), 64'(0));
   endtask

   // Register-file responder: data valid the cycle after rf_en, random noise otherwise.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.rf_readdata = en_s ? mem[reg_s] : $urandom;
      end
   end

   // Stream monitor: checks read addresses, element order/content and hold stability.
   initial begin
      elem_t e;
      forever begin
         @(negedge clk);
         en_s  = bus.rf_en;
         reg_s = int'(bus.rf_reg);
         if (!resetn) begin
            hold_v = 1'b0;
         end else if (bus.cancel) begin
            chk("rf_en_on_cancel", 64'(bus.rf_en), 64'(0));
            exp_q.delete();
            addr_q.delete();
            hold_v = 1'b0;
         end else begin
            if (bus.rf_en) begin
               rd_cnt++;
               if (addr_q.size() == 0) chk("rf_unexpected", 64'(1), 64'(0));
               else                    chk("rf_reg", 64'(bus.rf_reg), 64'(addr_q.pop_front()));
            end
            if (bus.out_valid) begin
               ov_cnt++;
               if (hold_v) begin
                  chk("hold_data", 64'(bus.out_data), 64'(hold_d));
                  chk("hold_idx", 64'(bus.out_idx), 64'(hold_i));
               end
               if (bus.out_ready) begin
                  hold_v = 1'b0;
                  if (exp_q.size() == 0) begin
                     chk("out_unexpected", 64'(1), 64'(0));
                  end else begin
                     e = exp_q.pop_front();
                     chk("out_data", 64'(bus.out_data), 64'(e.data));
                     chk("out_idx", 64'(bus.out_idx), 64'(e.idx));
                     chk("out_last", 64'(bus.out_last), 64'(e.last));
                  end
               end else begin
                  hold_v = 1'b1;
                  hold_d = bus.out_data;
                  hold_i = int'(bus.out_idx);
               end
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   end

   initial begin
      int rd0;
      int ov0;
      bus.req_valid   = 1'b0;
      bus.req_base    = '0;
      bus.req_len     = '0;
      bus.cancel      = 1'b0;
      bus.out_ready   = 1'b0;
      bus.rf_readdata = '0;
      fill_mem();

      // Reset state
      cyc(2);
      chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_rf_en", 64'(bus.rf_en), 64'(0));
      chk("rst_rf_reg", 64'(bus.rf_reg), 64'(0));
      resetn = 1'b1;
      cyc(1);

      // Scenario 1: base 3, len 4, consumer always ready, with latency check
      bus.out_ready = 1'b1;
      request(3, 4);
      chk("s1_rf_en_first", 64'(bus.rf_en), 64'(1));
      chk("s1_ov_c1", 64'(bus.out_valid), 64'(0));
      cyc(1);
      chk("s1_ov_c2", 64'(bus.out_valid), 64'(0));
      cyc(1);
      chk("s1_ov_c3", 64'(bus.out_valid), 64'(1));
      chk("s1_idx_c3", 64'(bus.out_idx), 64'(0));
      drain(50, 1'b0);
      chk("s1_req_ready", 64'(bus.req_ready), 64'(1));

      // Scenario 2: address wrap
      fill_mem();
      request(14, 5);
      drain(50, 1'b0);

      // Scenario 3: consumer stalled for 6 cycles
      fill_mem();
      bus.out_ready = 1'b0;
      rd0 = rd_cnt;
      request(7, 4);
      cyc(5);
      chk("s3_reads", 64'(rd_cnt - rd0), 64'(2));
      chk("s3_out_valid", 64'(bus.out_valid), 64'(1));
      chk("s3_head_idx", 64'(bus.out_idx), 64'(0));
      chk("s3_head_data", 64'(bus.out_data), 64'(mem[7]));
      bus.out_ready = 1'b1;
      drain(50, 1'b0);

      // Scenario 4: zero-length request
      rd0 = rd_cnt;
      ov0 = ov_cnt;
      request(5, 0);
      for (int i = 0; i < 4; i++) begin
         chk("s4_req_ready", 64'(bus.req_ready), 64'(1));
         cyc(1);
      end
      chk("s4_no_reads", 64'(rd_cnt - rd0), 64'(0));
      chk("s4_no_output", 64'(ov_cnt - ov0), 64'(0));

      // Scenario 5: cancel mid-sequence, then a single-element request
      fill_mem();
      request(0, 16);
      cyc(2);
      bus.cancel = 1'b1;
      cyc(1);
      bus.cancel = 1'b0;
      chk("s5_out_valid", 64'(bus.out_valid), 64'(0));
      chk("s5_req_ready", 64'(bus.req_ready), 64'(1));
      ov0 = ov_cnt;
      request(0, 1);
      drain(50, 1'b0);
      chk("s5_one_elem", 64'(ov_cnt - ov0), 64'(1));

      // Scenario 6: asynchronous reset with the FIFO full
      fill_mem();
      bus.out_ready = 1'b0;
      request(2, 6);
      cyc(4);
      chk("s6_full_valid", 64'(bus.out_valid), 64'(1));
      #2;
      resetn = 1'b0;
      #1;
      chk("s6_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("s6_rst_rf_en", 64'(bus.rf_en), 64'(0));
      chk("s6_rst_rf_reg", 64'(bus.rf_reg), 64'(0));
      chk("s6_rst_out_data", 64'(bus.out_data), 64'(0));
      chk("s6_rst_out_idx", 64'(bus.out_idx), 64'(0));
      chk("s6_rst_out_last", 64'(bus.out_last), 64'(0));
      chk("s6_rst_req_ready", 64'(bus.req_ready), 64'(1));
      exp_q.delete();
      addr_q.delete();
      cyc(2);
      resetn = 1'b1;
      bus.out_ready = 1'b1;
      rd0 = rd_cnt;
      ov0 = ov_cnt;
      cyc(6);
      chk("s6_no_stale_out", 64'(ov_cnt - ov0), 64'(0));
      chk("s6_no_reads", 64'(rd_cnt - rd0), 64'(0));

      // Randomized requests with a randomly stalling consumer
      for (int k = 0; k < 8; k++) begin
         fill_mem();
         request(int'($urandom_range(0, NUMREGS - 1)), int'($urandom_range(0, NUMREGS)));
         drain(400, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vread_sequencer.md
VREAD_SEQUENCER -- requirements
Module: vread_sequencer

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
REQ-002 WIDTH, 32, element data width.
REQ-003 NUMREGS, 16, register-file depth.
REQ-004 LOG2NUMREGS, 4, register address width.
REQ-005 Ports SHALL be one per line: name, direction, width, meaning. Clock and reset come first.
REQ-006 Single clock and reset: clk, in, 1, rising-edge clock; resetn, in, 1, reset, asynchronous and active-low.
REQ-007 req_valid, in, 1, a vector-read request is offered.
REQ-008 req_ready, out, 1, the block accepts a request this cycle.
REQ-009 req_base, in, LOG2NUMREGS, first register index.
REQ-010 req_len, in, LOG2NUMREGS+1, element count, legal range 0..NUMREGS.
REQ-011 cancel, in, 1, synchronous abort of the current sequence.
REQ-012 rf_reg, out, LOG2NUMREGS, register-file read address.
REQ-013 rf_en, out, 1, register-file read enable.
REQ-014 rf_readdata, in, WIDTH, register-file read data, valid exactly one cycle after rf_en=1.
REQ-015 out_valid, out, 1, an output element is available.
REQ-016 out_ready, in, 1, the consumer accepts the output element.
REQ-017 out_data, out, WIDTH, element data.
REQ-018 out_idx, out, LOG2NUMREGS, element index, 0-based.
REQ-019 out_last, out, 1, the element is the final element of the sequence.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN, DRAIN. req_ready SHALL equal (state==IDLE).
REQ-021 IDLE with req_valid=1 and req_len>0: SHALL latch base and len, zero the issue counter, and enter RUN.
REQ-022 IDLE with req_valid=1 and req_len=0: SHALL consume the request, stay in IDLE, and produce no output.
REQ-023 RUN: on each issue cycle, SHALL drive rf_en=1 and rf_reg=(base+issue_cnt) mod NUMREGS, wrapping from NUMREGS-1 to 0.
REQ-024 Issue condition: fifo_count + inflight - pop < 2, where pop = out_valid & out_ready.
REQ-025 RUN SHALL move to DRAIN in the cycle the element with issue_cnt = len-1 is issued.
REQ-026 The cycle after any issue, the block SHALL capture rf_readdata into a 2-entry FIFO together with its idx and last (idx==len-1).
REQ-027 rf_readdata SHALL be ignored in any cycle where no read is in flight.
REQ-028 DRAIN SHALL move to IDLE when inflight=0, the FIFO is empty, and no push is occurring.
REQ-029 out_valid SHALL equal FIFO not-empty. out_data, out_idx, and out_last SHALL come from the FIFO head and stay stable while out_valid=1 and out_ready=0.
REQ-030 A simultaneous push and pop on the FIFO SHALL preserve the count. The FIFO SHALL never overflow.
REQ-031 With out_ready held at 1, throughput SHALL be one element per cycle. The first out_valid SHALL appear 2 cycles after request acceptance.
REQ-032 cancel=1 (any state) SHALL, on the next edge: clear the FIFO, discard in-flight data, return to IDLE, and deassert rf_en in that same cycle.
REQ-033 cancel SHALL take priority over a request accepted in the same cycle; that request is dropped.
REQ-034 Elements SHALL be emitted strictly in index order, with no duplicates or gaps.

Reset
REQ-035 On resetn low, the block SHALL immediately enter IDLE with: FIFO empty, inflight=0, out_valid=0, rf_en=0, rf_reg=0, out_data=0, out_idx=0, out_last=0, and req_ready=1.
REQ-036 Reset mid-sequence SHALL abandon the sequence. No output SHALL appear after resetn rises until a new request is accepted.

Structure
REQ-037 A shared package vread_pkg SHALL hold the FSM state enumeration and the FIFO depth constant (2).
REQ-038 The 2-entry FIFO SHALL be a sub-module named vread_skid, parameterised by payload width.

Verification
REQ-039 Scenario 1: base=3, len=4, out_ready=1. Required: rf_reg sequence 3,4,5,6; out_idx 0..3; out_last only on idx 3; req_ready returns to 1 after the last pop.
REQ-040 Scenario 2: base=14, len=5. Required: rf_reg sequence 14,15,0,1,2.
REQ-041 Scenario 3: len=4 with out_ready=0 for 6 cycles after acceptance. Required: exactly 2 reads issued, FIFO full, out_data stable; after release, all 4 elements delivered in order.
REQ-042 Scenario 4: req_len=0. Required: no rf_en, no out_valid, req_ready stays 1.
REQ-043 Scenario 5: len=16, cancel pulsed 3 cycles after acceptance. Required: out_valid=0 next cycle, IDLE reached, a new request with base=0, len=1 yields a single element, idx 0, last=1.
REQ-044 Scenario 6: resetn asserted mid-sequence with the FIFO full. Required: all outputs at reset values asynchronously, and no stale element after resetn is released.
